uart_tx_words: RTL

Parallel-to-serial UART transmitter for the MVM result path. It accepts one W_OUT-bit result bus through a valid/ready handshake and splits it into N_WORDS = W_OUT/BITS_PER_WORD words, sent low word first. Each word goes out as one UART packet: a start bit, the data bits LSB first, then stop/padding ones. It sits between the MVM output register and the tx pin, and is the counterpart of the UART receiver that feeds K and X into the array.

---
 rtl/uart_tx_words.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_words.sv
// uart_tx_words
// -----------------------------------------------------------------------------
// Parallel-to-serial UART transmitter for the MVM result path. One W_OUT-bit
// result is captured through a valid/ready handshake. It is then sent as
// N_WORDS back-to-back UART packets, low word first. Each packet is one start
// bit (0), BITS_PER_WORD data bits LSB first, and N_PAD padding/stop bits (1).
//
// Ports:
//   clk      in   rising-edge clock
//   rstn     in   asynchronous active-low reset
//   s_valid  in   upstream has a result on s_data
//   s_data   in   [W_OUT-1:0] result bus; word 0 = s_data[BITS_PER_WORD-1:0]
//   s_ready  out  high while idle; the block can capture s_data
//   tx       out  UART serial line, idle high, driven from a flop
//
// Parameter constraints:
//   CLOCKS_PER_PULSE >= 2
//   PACKET_SIZE      >= BITS_PER_WORD + 2
//   W_OUT            a multiple of BITS_PER_WORD
// -----------------------------------------------------------------------------
module uart_tx_words #(
  parameter int CLOCKS_PER_PULSE = 200_000_000 / 9600,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE      = BITS_PER_WORD + 5,
  parameter int W_OUT            = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             s_valid,
  input  logic [W_OUT-1:0] s_data,
  output logic             s_ready,
  output logic             tx
);

  localparam int N_WORDS = W_OUT / BITS_PER_WORD;
  localparam int N_PAD   = PACKET_SIZE - BITS_PER_WORD - 1;
  localparam int N_BITS  = N_WORDS * PACKET_SIZE;

  // Counter widths are sized to hold the last count value.
  localparam int PW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(N_BITS - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  // ---------------------------------------------------------------------------
  // Frame packing: word w occupies bits [w*PACKET_SIZE +: PACKET_SIZE] and is
  // laid out LSB-first on the line as {pad ones, data word, start bit}.
  // ---------------------------------------------------------------------------
  logic [N_BITS-1:0] frame_packed;

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_pack
    assign frame_packed[gi*PACKET_SIZE +: PACKET_SIZE] =
      {{N_PAD{1'b1}}, s_data[gi*BITS_PER_WORD +: BITS_PER_WORD], 1'b0};
  end

  // ---------------------------------------------------------------------------
  // State
  // The bit currently on the line lives in tx_q. shift_q holds only the bits
  // still to come (frame bits 1..N_BITS-1), so its LSB is the next bit to send.
  // ---------------------------------------------------------------------------
  logic [0:0]        state_q,     state_d;
  logic              ready_q,     ready_d;
  logic              tx_q,        tx_d;
  logic [N_BITS-2:0] shift_q,     shift_d;
  logic [PW-1:0]     pulse_cnt_q, pulse_cnt_d;
  logic [BW-1:0]     bit_cnt_q,   bit_cnt_d;

  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    tx_d        = tx_q;
    shift_d     = shift_q;
    pulse_cnt_d = pulse_cnt_q;
    bit_cnt_d   = bit_cnt_q;

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (s_valid && ready_q) begin
          state_d     = SEND;
          ready_d     = 1'b0;
          // The start bit of word 0 goes straight onto the line.
          tx_d        = frame_packed[0];
          shift_d     = frame_packed[N_BITS-1:1];
          pulse_cnt_d = '0;
          bit_cnt_d   = '0;
        end
      end

      default: begin // SEND
        if (pulse_cnt_q == PULSE_LAST) begin
          pulse_cnt_d = '0;
          if (bit_cnt_q == BIT_LAST) begin
            // The last pad bit has had its full pulse: return to idle.
            state_d   = IDLE;
            ready_d   = 1'b1;
            tx_d      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[N_BITS-2:1]};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      tx_q        <= 1'b1;
      shift_q     <= '1;
      pulse_cnt_q <= '0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      tx_q        <= tx_d;
      shift_q     <= shift_d;
      pulse_cnt_q <= pulse_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign s_ready = ready_q;
  assign tx      = tx_q;

endmodule
